branch_resolve_queue: RTL and testbench

Parametrised branch-resolution feedback unit between the EX stage and the IF-stage predictor (BTB + GShare). It accepts up to NCH resolved branches per cycle and produces one registered front-end redirect (PC and GHSR restore) for the oldest mispredict. It also buffers predictor-training updates in an in-order FIFO drained by the predictor with a valid/ready handshake. It succeeds the single-channel, unbuffered EX-to-IF branch bundle.

---
 rtl/branch_resolve_queue.sv | 133 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// Resolves up to NCH branches/cycle: registered redirect for the oldest mispredict (1 cycle) plus an in-order
// training FIFO (enqueue visible next cycle); upd_valid/upd_ready backpressure, overflow entries are dropped and counted.
module branch_resolve_queue #(
    parameter int NCH    = 2,
    parameter int DEPTH  = 8,
    parameter int GHSR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_flush,
    input  logic [NCH-1:0]          in_valid,
    input  logic [NCH-1:0]          in_taken,
    input  logic [NCH-1:0]          in_mispred,
    input  logic [NCH-1:0]          in_rvc,
    input  logic [NCH*32-1:0]       in_pc,
    input  logic [NCH*32-1:0]       in_target,
    input  logic [NCH*GHSR_W-1:0]   in_ghsr,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_addr,
    output logic [GHSR_W-1:0]       redirect_ghsr,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [31:0]             upd_pc,
    output logic [31:0]             upd_target,
    output logic                    upd_taken,
    output logic                    upd_mispred,
    output logic [GHSR_W-1:0]       upd_ghsr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic [15:0]             drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       target;
        logic              taken;
        logic              mispred;
        logic [GHSR_W-1:0] ghsr;
    } upd_t;

    upd_t              mem [DEPTH];
    upd_t              entry [NCH];
    upd_t              head;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [NCH-1:0]    enq_ok;
    logic [PW-1:0]     enq_off [NCH];
    int                enq_n, drop_n;
    logic              found;
    logic [31:0]       redir_addr_d;
    logic [GHSR_W-1:0] redir_ghsr_d;
    logic              deq;
    logic [16:0]       drop_sum;

    // Walk channels oldest-first; once a mispredict is seen, younger channels are wrong-path.
    always_comb begin
        int acc_n;
        int free;
        acc_n        = 0;
        enq_n        = 0;
        drop_n       = 0;
        found        = 1'b0;
        redir_addr_d = '0;
        redir_ghsr_d = '0;
        enq_ok       = '0;
        free         = DEPTH - int'(count);
        for (int i = 0; i < NCH; i++) begin
            entry[i]   = '{pc: in_pc[i*32 +: 32], target: in_target[i*32 +: 32],
                           taken: in_taken[i], mispred: in_mispred[i],
                           ghsr: in_ghsr[i*GHSR_W +: GHSR_W]};
            enq_off[i] = '0;
            if (in_valid[i] && !in_flush && !found) begin
                if (acc_n < free) begin
                    enq_ok[i]  = 1'b1;
                    enq_off[i] = PW'(acc_n);
                    enq_n      = enq_n + 1;
                end else begin
                    drop_n = drop_n + 1;
                end
                acc_n = acc_n + 1;
                if (in_mispred[i]) begin
                    found        = 1'b1;
                    redir_addr_d = in_taken[i] ? in_target[i*32 +: 32]
                                               : in_pc[i*32 +: 32] + (in_rvc[i] ? 32'd2 : 32'd4);
                    redir_ghsr_d = in_ghsr[i*GHSR_W +: GHSR_W];
                end
            end
        end
    end

    assign upd_valid   = (count != '0);
    assign full        = (count == CW'(DEPTH));
    assign deq         = upd_valid & upd_ready;
    assign drop_sum    = {1'b0, drop_cnt} + 17'(drop_n);
    // Head fields read as zero while empty so stale storage never shows on the outputs.
    assign head        = upd_valid ? mem[rd_ptr] : '0;
    assign upd_pc      = head.pc;
    assign upd_target  = head.target;
    assign upd_taken   = head.taken;
    assign upd_mispred = head.mispred;
    assign upd_ghsr    = head.ghsr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                if (enq_ok[i]) mem[wr_ptr + enq_off[i]] <= entry[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            drop_cnt       <= '0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
            redirect_ghsr  <= '0;
        end else begin
            wr_ptr         <= wr_ptr + PW'(enq_n);
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count          <= count + CW'(enq_n) - CW'(deq);
            drop_cnt       <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            redirect_valid <= found;
            if (found) begin
                redirect_addr <= redir_addr_d;
                redirect_ghsr <= redir_ghsr_d;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (NCH=2, DEPTH=8, GHSR_W=8).
module tb_branch_resolve_queue;
    localparam int NCH = 2;
    localparam int DEPTH = 8;
    localparam int GW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_flush;
    logic [NCH-1:0]  in_valid, in_taken, in_mispred, in_rvc;
    logic [NCH*32-1:0] in_pc, in_target;
    logic [NCH*GW-1:0] in_ghsr;
    logic            redirect_valid;
    logic [31:0]     redirect_addr;
    logic [GW-1:0]   redirect_ghsr;
    logic            upd_valid, upd_ready;
    logic [31:0]     upd_pc, upd_target;
    logic            upd_taken, upd_mispred;
    logic [GW-1:0]   upd_ghsr;
    logic [3:0]      count;
    logic            full;
    logic [15:0]     drop_cnt;

    int errs = 0;
    int checks = 0;

    branch_resolve_queue #(.NCH(NCH), .DEPTH(DEPTH), .GHSR_W(GW)) dut (
        .clk(clk), .reset(reset), .in_flush(in_flush), .in_valid(in_valid),
        .in_taken(in_taken), .in_mispred(in_mispred), .in_rvc(in_rvc),
        .in_pc(in_pc), .in_target(in_target), .in_ghsr(in_ghsr),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .redirect_ghsr(redirect_ghsr), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .upd_mispred(upd_mispred), .upd_ghsr(upd_ghsr), .count(count),
        .full(full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_flush   = 1'b0;
        in_valid   = '0;
        in_taken   = '0;
        in_mispred = '0;
        in_rvc     = '0;
        in_pc      = '0;
        in_target  = '0;
        in_ghsr    = '0;
    endtask

    task automatic set_ch(input int i, input logic tk, input logic mp, input logic rvc,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic [GW-1:0] gh);
        in_valid[i]          = 1'b1;
        in_taken[i]          = tk;
        in_mispred[i]        = mp;
        in_rvc[i]            = rvc;
        in_pc[i*32 +: 32]    = pc;
        in_target[i*32 +: 32] = tgt;
        in_ghsr[i*GW +: GW]  = gh;
    endtask

    initial begin
        clr();
        upd_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        check("rst_count", 32'(count), 0);
        check("rst_upd_valid", 32'(upd_valid), 0);
        check("rst_redir_valid", 32'(redirect_valid), 0);
        check("rst_full", 32'(full), 0);
        reset = 1'b0;

        // Fill 3, then reset while a mispredict is presented
        for (int e = 0; e < 3; e++) begin
            clr();
            set_ch(0, 1'b0, 1'b0, 1'b0, 32'h10 + 32'(4 * e), 32'h0, 8'h0);
            step();
        end
        clr();
        check("fill3_count", 32'(count), 3);
        set_ch(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h4000, 8'h77);
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr();
        check("midrst_count", 32'(count), 0);
        check("midrst_upd_valid", 32'(upd_valid), 0);
        check("midrst_redir_valid", 32'(redirect_valid), 0);
        check("midrst_redir_addr", redirect_addr, 0);
        check("midrst_drop", 32'(drop_cnt), 0);

        // Single mispredict, not-taken compressed
        set_ch(0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h900, 8'h5A);
        step();
        clr();
        check("single_redir_valid", 32'(redirect_valid), 1);
        check("single_redir_addr", redirect_addr, 32'h102);
        check("single_redir_ghsr", 32'(redirect_ghsr), 32'h5A);
        check("single_count", 32'(count), 1);
        check("single_upd_pc", upd_pc, 32'h100);
        check("single_upd_mispred", 32'(upd_mispred), 1);
        check("single_upd_taken", 32'(upd_taken), 0);
        check("single_upd_ghsr", 32'(upd_ghsr), 32'h5A);
        step();
        check("single_pulse_end", 32'(redirect_valid), 0);
        check("single_addr_hold", redirect_addr, 32'h102);
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        check("single_drained", 32'(count), 0);

        // ch0 mispredict squashes ch1
        set_ch(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h2000, 8'h11);
        set_ch(1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h3000, 8'h22);
        step();
        clr();
        check("sq_redir_valid", 32'(redirect_valid), 1);
        check("sq_redir_addr", redirect_addr, 32'h2000);
        check("sq_redir_ghsr", 32'(redirect_ghsr), 32'h11);
        check("sq_count", 32'(count), 1);
        check("sq_drop", 32'(drop_cnt), 0);
        check("sq_upd_pc", upd_pc, 32'h200);
        check("sq_upd_target", upd_target, 32'h2000);
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;

        // ch0 correct, ch1 mispredict not-taken 4-byte
        set_ch(0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h480, 8'h01);
        set_ch(1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h5000, 8'h33);
        step();
        clr();
        check("ord_redir_valid", 32'(redirect_valid), 1);
        check("ord_redir_addr", redirect_addr, 32'h504);
        check("ord_redir_ghsr", 32'(redirect_ghsr), 32'h33);
        check("ord_count", 32'(count), 2);
        check("ord_head0_pc", upd_pc, 32'h400);
        check("ord_head0_taken", 32'(upd_taken), 1);
        upd_ready = 1'b1;
        step();
        check("ord_head1_pc", upd_pc, 32'h500);
        check("ord_head1_mispred", 32'(upd_mispred), 1);
        step();
        upd_ready = 1'b0;
        check("ord_drained", 32'(count), 0);

        // Overflow: 10 entries offered into 8 slots
        for (int c = 0; c < 5; c++) begin
            clr();
            set_ch(0, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(8 * c), 32'h0, 8'h0);
            set_ch(1, 1'b0, 1'b0, 1'b0, 32'h1004 + 32'(8 * c), 32'h0, 8'h0);
            step();
        end
        clr();
        check("ovf_count", 32'(count), 8);
        check("ovf_full", 32'(full), 1);
        check("ovf_drop", 32'(drop_cnt), 2);
        check("ovf_head", upd_pc, 32'h1000);

        // Full with simultaneous dequeue and enqueue attempt
        upd_ready = 1'b1;
        set_ch(0, 1'b0, 1'b0, 1'b0, 32'hDEAD0, 32'h0, 8'h0);
        step();
        clr();
        check("fulldeq_count", 32'(count), 7);
        check("fulldeq_drop", 32'(drop_cnt), 3);
        check("fulldeq_full", 32'(full), 0);
        for (int j = 1; j < 8; j++) begin
            check("drain_pc", upd_pc, 32'h1000 + 32'(4 * j));
            step();
        end
        upd_ready = 1'b0;
        check("drain_count", 32'(count), 0);
        check("drain_upd_valid", 32'(upd_valid), 0);

        // Flush squashes everything
        in_flush = 1'b1;
        set_ch(0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h6000, 8'h44);
        set_ch(1, 1'b1, 1'b1, 1'b0, 32'h700, 32'h7000, 8'h55);
        step();
        clr();
        check("flush_redir_valid", 32'(redirect_valid), 0);
        check("flush_count", 32'(count), 0);
        check("flush_drop", 32'(drop_cnt), 3);

        // Stream 20 entries through with continuous dequeue; pointers wrap
        upd_ready = 1'b1;
        for (int e = 0; e < 20; e++) begin
            clr();
            set_ch(0, 1'b0, 1'b0, 1'b0, 32'h8000 + 32'(4 * e), 32'h0, 8'h0);
            step();
            check("wrap_count", 32'(count), 1);
            check("wrap_pc", upd_pc, 32'h8000 + 32'(4 * e));
        end
        clr();
        step();
        check("wrap_final_count", 32'(count), 0);
        check("wrap_final_drop", 32'(drop_cnt), 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
